// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - 32-iteration unsigned multiply/divide unit with register-file write-back beat
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [4:0]  dest,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  wreg,
    output logic        write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  op_q;
    logic [31:0] m_q;
    logic [31:0] sq;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic [4:0]  dest_q;
    logic        fin;

    logic        capture;
    logic        step;
    logic        finish;

    logic        is_div;
    logic [32:0] add_sum;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        rem_ge;
    logic [63:0] acc_mul;
    logic [63:0] acc_div;
    logic [31:0] res_sel;

    // fin marks that all 32 iterations are in; the following RUN cycle latches the result.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (fin) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    capture  = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // sq holds the multiplier (shifted right) or the dividend (shifted left into rem).
    always_comb begin
        is_div   = op_q[1];
        add_sum  = {1'b0, acc[63:32]} + (sq[0] ? {1'b0, m_q} : 33'd0);
        rem_sh   = {acc[63:32], sq[31]};
        rem_ge   = (rem_sh >= {1'b0, m_q});
        rem_diff = rem_sh - {1'b0, m_q};
        acc_mul  = {add_sum, acc[31:1]};
        acc_div  = {(rem_ge ? rem_diff[31:0] : rem_sh[31:0]), acc[30:0], rem_ge};
        case (op_q)
            2'b00:   res_sel = acc[31:0];
            2'b01:   res_sel = acc[63:32];
            2'b10:   res_sel = acc[31:0];
            default: res_sel = acc[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            m_q    <= 32'd0;
            sq     <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            dest_q <= 5'd0;
            fin    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            write  <= 1'b0;
            result <= 32'd0;
            wreg   <= 5'd0;
        end else begin
            state <= state_nx;
            if (capture) begin
                op_q   <= op;
                m_q    <= opb;
                sq     <= opa;
                dest_q <= dest;
                acc    <= 64'd0;
                cnt    <= 5'd31;
                fin    <= 1'b0;
                busy   <= 1'b1;
                done   <= 1'b0;
                write  <= 1'b0;
            end else if (step) begin
                acc <= is_div ? acc_div : acc_mul;
                sq  <= is_div ? {sq[30:0], 1'b0} : {1'b0, sq[31:1]};
                if (cnt == 5'd0) begin
                    fin <= 1'b1;
                end else begin
                    cnt <= cnt - 5'd1;
                end
            end else if (finish) begin
                fin    <= 1'b0;
                result <= res_sel;
                wreg   <= dest_q;
                done   <= 1'b1;
                write  <= 1'b1;
            end else begin
                done  <= 1'b0;
                write <= 1'b0;
                if (state == DONE) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  dest;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wreg;
    logic        write;

    int cmps;
    int errs;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .dest   (dest),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wreg   (wreg),
        .write  (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op, scrambles the inputs after capture, and checks latency and the write-back beat.
    // pulse_at > 0 re-asserts start with other operands so it is sampled at edge E<pulse_at>.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input int pulse_at);
        int          lat;
        logic [31:0] exp;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; dest = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        opa   = $urandom;
        opb   = $urandom;
        dest  = 5'($urandom);
        chk({tag, " busy_after_e0"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (pulse_at > 0 && lat == pulse_at - 1) begin
                start = 1'b1; opa = ~a; opb = b + 32'd3; dest = ~d; op = ~o;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " result"}, result, exp);
        chk({tag, " wreg"}, 32'(wreg), 32'(d));
        chk({tag, " write"}, 32'(write), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, " done_fall"}, {29'd0, busy, done, write}, 32'd0);
        chk({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] e1;
        logic [31:0] e2;
        cmps  = 0;
        errs  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        opa   = 32'd0;
        opb   = 32'd0;
        dest  = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, busy, done, write, 2'b00}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_wreg", 32'(wreg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul_7x6", 2'd0, 32'd7, 32'd6, 5'd5, 0);
        do_op("mulh_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0);
        do_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
        do_op("div_100_7", 2'd2, 32'd100, 32'd7, 5'd1, 0);
        do_op("rem_100_7", 2'd3, 32'd100, 32'd7, 5'd2, 0);
        do_op("div_5_9", 2'd2, 32'd5, 32'd9, 5'd3, 0);
        do_op("rem_5_9", 2'd3, 32'd5, 32'd9, 5'd4, 0);
        do_op("div_by_zero", 2'd2, 32'h1234_5678, 32'd0, 5'd31, 0);
        do_op("rem_by_zero", 2'd3, 32'h1234_5678, 32'd0, 5'd0, 0);
        do_op("start_ignored", 2'd0, 32'd1234, 32'd5678, 5'd17, 10);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(0, 300)) : $urandom;
            do_op($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom), 0);
        end

        // Start held high: second op is captured at E34 from the same operand set.
        e1 = model(2'd0, 32'd123456, 32'd789);
        e2 = model(2'd3, 32'hDEAD_BEEF, 32'd1000);
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 32'd123456; opb = 32'd789; dest = 5'd7;
        @(posedge clk);
        @(negedge clk);
        op = 2'd3; opa = 32'hDEAD_BEEF; opb = 32'd1000; dest = 5'd8;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd33);
        chk("b2b_first_result", result, e1);
        chk("b2b_first_wreg", 32'(wreg), 32'd7);
        @(negedge clk);
        lat++;
        chk("b2b_busy_at_e34", {30'd0, busy, done}, 32'd2);
        while (!done && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("b2b_second_latency", 32'(lat), 32'd67);
        chk("b2b_second_result", result, e2);
        chk("b2b_second_wreg", 32'(wreg), 32'd8);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-MUL at E15.
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 32'd99; opb = 32'd77; dest = 5'd12;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_flags", {29'd0, busy, done, write}, 32'd0);
        chk("reset_mid_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || write || busy) seen++;
        end
        chk("reset_no_write_pulse", 32'(seen), 32'd0);
        do_op("after_reset_mul", 2'd0, 32'd99, 32'd77, 5'd12, 0);
        do_op("after_reset_div", 2'd2, 32'hFFFF_FFFF, 32'd3, 5'd13, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
